weight_out_feeder: RTL
======================

Name: weight_out_feeder

Overview:
- Producer-side front end for `weight_in_ctrl`: it drives that block's write FIFO, load and clear inputs.
- Accepts a byte stream of 8-bit filter weights on a valid/ready slave interface.
- Packs PARAM_S weights per filter row into one MSB-justified 32-bit word and writes PARAM_R rows into the weight FIFO.
- Then issues LOAD_WS, waits for WS_FULL and clears the FIFO, so the MLP/conv datapath sees a loaded weight store and a clean FIFO for the next tile.

Parameters:
- WORD_WIDTH, 32, FIFO word width; equals the `weight_in_ctrl` INPUT_WIDTH.
- BYTE_WIDTH, 8, width of one weight.
- MAX_R, 5, maximum rows; equals the weight-store depth.
- MAX_S, 4, maximum weights per row; equals WORD_WIDTH/BYTE_WIDTH.
- WS_TIMEOUT, 20, maximum cycles LOAD_WS is held waiting for WS_FULL.

Ports:
- CLK  in  1  clock.
- RESETN  in  1  active-low reset.
- START  in  1  one-cycle request to begin a weight tile.
- PARAM_R  in  4  rows to send, 1..MAX_R.
- PARAM_S  in  4  weights per row, 1..MAX_S.
- BUSY  out  1  high from accepted START until DONE.
- DONE  out  1  one-cycle pulse when the tile is complete.
- ERR  out  1  one-cycle pulse on a bad parameter, a TLAST mismatch or a WS_FULL timeout.
- S_TDATA  in  BYTE_WIDTH  weight byte.
- S_TVALID  in  1  byte valid.
- S_TREADY  out  1  byte accepted when S_TVALID && S_TREADY.
- S_TLAST  in  1  marks the final byte of the tile.
- FIFO_WR_CMD  out  1  write strobe to `weight_in_ctrl`.
- FIFO_WR_DATA  out  WORD_WIDTH  packed row word.
- FIFO_FULL  in  1  weight FIFO full.
- LOAD_WS  out  1  load command to the weight store.
- WS_FULL  in  1  weight store full; may be a single-cycle pulse.
- CLEAR_FIFO  out  1  FIFO clear.

Behaviour:
- Clocking and reset:
  - Single clock CLK; RESETN is asynchronous, active-low.
  - During reset, all outputs are 0, state is IDLE and the counters and word register are cleared.
- Reset mid-operation: the tile is abandoned immediately. No DONE is issued. Any partial word already written is not retracted; recovery is the master's job.
- IDLE:
  - On START, latch PARAM_R/PARAM_S.
  - If R is outside 1..MAX_R or S is outside 1..MAX_S: pulse ERR next cycle and stay IDLE.
  - Otherwise set BUSY and go to PACK.
  - START while BUSY is ignored.
- PACK:
  - S_TREADY = 1.
  - The k-th accepted byte of a row (k = 0..S-1) goes to word bits [WORD_WIDTH-1-8k -: 8]; unused LSBs are 0.
  - On the S-th byte, go to WRITE.
- TLAST check: S_TLAST must coincide with the last byte of row R-1. If TLAST is seen early, or is missing on that byte, ERR pulses once and packing continues with the counts unchanged.
- WRITE:
  - S_TREADY = 0.
  - FIFO_WR_CMD = 1 with FIFO_WR_DATA = the word, for exactly one cycle, and only when FIFO_FULL = 0; otherwise hold in WRITE.
  - Row-to-FIFO latency is 1 cycle after the last byte handshake when the FIFO is not full.
  - Increment the row counter. If rows == R, go to LOAD; else go to PACK.
  - FIFO_WR_DATA is 0 whenever FIFO_WR_CMD = 0.
- LOAD:
  - LOAD_WS = 1 each cycle, with a cycle counter.
  - On WS_FULL sampled high, drop LOAD_WS next cycle and go to CLEAR.
  - If the counter reaches WS_TIMEOUT: ERR pulse, LOAD_WS = 0, go to CLEAR anyway.
- CLEAR: CLEAR_FIFO = 1 for exactly one cycle, then CLEAR_WAIT.
- CLEAR_WAIT: one idle cycle, because the FIFO cannot accept data in the cycle after a clear. Then DONE pulses, BUSY drops and the state returns to IDLE.
- DONE and START together: a START in the same cycle as DONE is ignored; START is accepted from the next cycle.
- Minimum tile latency (FIFO never full, bytes every cycle, WS_FULL on the first LOAD cycle): R·(S+1) + 4 cycles from START to DONE.

Decomposition:
- Package `weight_feed_pkg` holds:
  - state enum {IDLE, PACK, WRITE, LOAD, CLEAR, CLEAR_WAIT};
  - WORD_WIDTH, BYTE_WIDTH, MAX_R, MAX_S;
  - the parameter-valid check function.
- Sub-module `weight_byte_packer` contains:
  - byte index counter;
  - MSB-justified shift-in word register with zero fill;
  - `word_done` flag;
  - clear on start of row.

Test Plan:
- R=1, S=1, byte 0xA5 -> one write of 0xA5000000; LOAD_WS held until WS_FULL; CLEAR_FIFO 1 cycle; DONE; total 6 cycles.
- R=4, S=4, bytes 0x00..0x0F, TLAST on 0x0F -> writes 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F; no ERR.
- R=3, S=3, FIFO_FULL forced high 5 cycles during the second write -> FIFO_WR_CMD held off, S_TREADY=0, the word is written unchanged after release, third row is 0x__ __ __00 (LSB byte zero).
- PARAM_S=0 or PARAM_R=6 -> ERR pulse, BUSY stays 0, no FIFO/LOAD activity.
- WS_FULL never asserted -> LOAD_WS high exactly 20 cycles, ERR, CLEAR_FIFO, DONE.
- RESETN low during WRITE of row 2 -> all outputs 0 asynchronously; a new START after release completes a clean R=2, S=2 tile.

Source files
------------

// File: rtl/weight_feed_pkg.sv
// Shared types, sizes and the tile-parameter check for the weight_out_feeder slice.
package weight_feed_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int BYTE_WIDTH = 8;
    localparam int MAX_R      = 5;
    localparam int MAX_S      = WORD_WIDTH / BYTE_WIDTH;
    localparam int WS_TIMEOUT = 20;

    // Widths of the tile parameters / row+byte counters and of the LOAD timeout counter.
    localparam int CNT_W = 4;
    localparam int TMO_W = 5;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PACK       = 3'd1,
        WRITE      = 3'd2,
        LOAD       = 3'd3,
        CLEAR      = 3'd4,
        CLEAR_WAIT = 3'd5
    } feed_state_e;

    // A tile is accepted only when both R and S fit the weight store and the word.
    function automatic logic params_valid(input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] s);
        return (r >= CNT_W'(1)) && (r <= CNT_W'(MAX_R)) &&
               (s >= CNT_W'(1)) && (s <= CNT_W'(MAX_S));
    endfunction

endpackage

// File: rtl/weight_byte_packer.sv
// Packs accepted weight bytes of one row into an MSB-justified word, zero filled.
module weight_byte_packer
    import weight_feed_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  accept_i,
    input  logic [BYTE_WIDTH-1:0] byte_i,
    input  logic [CNT_W-1:0]      s_i,
    output logic [WORD_WIDTH-1:0] word_o,
    output logic                  word_done_o
);

    logic [CNT_W-1:0]      idx_q, idx_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;

    // The row is complete on the handshake of its S-th byte.
    assign word_done_o = accept_i && (idx_q == (s_i - CNT_W'(1)));
    assign word_o      = word_q;

    // Byte k lands at the k-th byte lane from the MSB; a clear restarts the row.
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear_i) begin
            idx_d  = '0;
            word_d = '0;
        end else if (accept_i) begin
            for (int k = 0; k < MAX_S; k++) begin
                if (idx_q == CNT_W'(k)) begin
                    word_d[WORD_WIDTH-1-BYTE_WIDTH*k -: BYTE_WIDTH] = byte_i;
                end
            end
            idx_d = word_done_o ? '0 : idx_q + CNT_W'(1);
        end
    end

    // Byte index and word register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/weight_out_feeder.sv
// Producer front end for weight_in_ctrl: packs a byte stream into row words,
// writes them to the weight FIFO, loads the weight store and clears the FIFO.
//
// Handshake: a byte moves on S_TDATA at a rising CLK edge where S_TVALID and
// S_TREADY are both high; S_TREADY depends only on the state, never on S_TVALID.
module weight_out_feeder
    import weight_feed_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  START,
    input  logic [CNT_W-1:0]      PARAM_R,
    input  logic [CNT_W-1:0]      PARAM_S,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR,
    input  logic [BYTE_WIDTH-1:0] S_TDATA,
    input  logic                  S_TVALID,
    output logic                  S_TREADY,
    input  logic                  S_TLAST,
    output logic                  FIFO_WR_CMD,
    output logic [WORD_WIDTH-1:0] FIFO_WR_DATA,
    input  logic                  FIFO_FULL,
    output logic                  LOAD_WS,
    input  logic                  WS_FULL,
    output logic                  CLEAR_FIFO,
    output logic [2:0]            DBG_STATE
);

    feed_state_e           state_q, state_d;
    logic [CNT_W-1:0]      r_q, r_d, s_q, s_d, row_q, row_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  err_q, err_d, done_q, done_d;
    logic                  accept, pk_clear, word_done, last_byte;
    logic [WORD_WIDTH-1:0] word;

    assign S_TREADY  = (state_q == PACK);
    assign accept    = S_TREADY && S_TVALID;
    assign last_byte = word_done && (row_q == (r_q - CNT_W'(1)));

    weight_byte_packer u_packer (
        .clk_i       (CLK),
        .rst_ni      (RESETN),
        .clear_i     (pk_clear),
        .accept_i    (accept),
        .byte_i      (S_TDATA),
        .s_i         (s_q),
        .word_o      (word),
        .word_done_o (word_done)
    );

    // Next state, counters and per-state strobes.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        s_d         = s_q;
        row_d       = row_q;
        tmo_d       = '0;
        err_d       = 1'b0;
        done_d      = 1'b0;
        pk_clear    = 1'b0;
        FIFO_WR_CMD = 1'b0;
        LOAD_WS     = 1'b0;
        CLEAR_FIFO  = 1'b0;
        case (state_q)
            IDLE: begin
                // A START coinciding with DONE belongs to the finished tile and is dropped.
                if (START && !done_q) begin
                    r_d = PARAM_R;
                    s_d = PARAM_S;
                    if (params_valid(PARAM_R, PARAM_S)) begin
                        state_d  = PACK;
                        row_d    = '0;
                        pk_clear = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PACK: begin
                if (accept) begin
                    // TLAST must mark exactly the last byte of the last row; counts are kept either way.
                    if (S_TLAST != last_byte) err_d = 1'b1;
                    if (word_done) state_d = WRITE;
                end
            end
            WRITE: begin
                if (!FIFO_FULL) begin
                    FIFO_WR_CMD = 1'b1;
                    pk_clear    = 1'b1;
                    row_d       = row_q + CNT_W'(1);
                    state_d     = ((row_q + CNT_W'(1)) == r_q) ? LOAD : PACK;
                end
            end
            LOAD: begin
                LOAD_WS = 1'b1;
                if (WS_FULL) begin
                    state_d = CLEAR;
                end else if (tmo_q == TMO_W'(WS_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = CLEAR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            CLEAR: begin
                CLEAR_FIFO = 1'b1;
                state_d    = CLEAR_WAIT;
            end
            CLEAR_WAIT: begin
                // The FIFO cannot take data right after a clear, so finish one cycle later.
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, tile parameters, counters and the registered DONE/ERR pulses.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            r_q     <= '0;
            s_q     <= '0;
            row_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            s_q     <= s_d;
            row_q   <= row_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign BUSY         = (state_q != IDLE);
    assign DONE         = done_q;
    assign ERR          = err_q;
    assign FIFO_WR_DATA = FIFO_WR_CMD ? word : '0;
    assign DBG_STATE    = state_q;

endmodule
